tm1638_responder: RTL and testbench
===================================

// Module: tm1638_responder
// PURPOSE
//  Slave end of the TM1638 STB/CLK/DIO link: emulates the chip so a board controller can be closed-loop simulated or drive an FPGA-hosted display.
//  Decodes data/address/display-control commands, holds the 16-byte display RAM and returns key-scan bytes on read commands.
// PARAMETERS
//  SYNC_STAGES  2  synchronizer depth on sio_clk, sio_stb, sio_data_in (>=2)
//  KEY_BYTES    4  bytes returned per read command
// PORTS
//  clk              in   1               system clock; single clock domain
//  rst_n            in   1               asynchronous active-low reset
//  sio_clk          in   1               serial clock from master (async)
//  sio_stb          in   1               strobe from master, active low (async)
//  sio_data_in      in   1               DIO as driven by master
//  sio_data_out     out  1               DIO value driven in read phase
//  sio_data_out_en  out  1               DIO drive enable (1 = responder drives)
//  key_scan         in   8*KEY_BYTES     key bytes; byte k = key_scan[8k+7:8k]
//  display_ram      out  128             RAM byte a = display_ram[8a+7:8a]
//  ram_wr_stb       out  1               1-clk pulse per RAM byte written
//  ram_wr_addr      out  4               address of that write
//  ram_wr_data      out  8               data of that write
//  disp_on          out  1               display-control bit3
//  brightness       out  3               display-control bits[2:0]
//  frame_err        out  1               1-clk pulse: STB rose with partial byte
// BEHAVIOUR
//  Reset: all outputs 0; RAM all 0; addr=0; mode=write/auto-increment.
//  Inputs pass SYNC_STAGES flops; edges detected on synced copies. sio_clk high and low phases must each be >=3 clk.
//  Frame = sio_stb low..high. STB falling clears bit count; the first byte is the command.
//  Bits are LSB first. Master-to-slave bits are sampled on sio_clk rising edge from synced sio_data_in.
//  A byte completes on its 8th rising edge. Its action takes effect 1 clk after that edge is detected.
//  FSM: IDLE -> CMD (STB low) -> {WDATA, READ, IGNORE}; any state -> IDLE on STB high.
//  Command byte decode:
//   01xx_xmrx: data cmd. r=1 -> READ; r=0 -> set mode (m=1 fixed address, m=0 auto-increment), then IGNORE.
//   11xx_aaaa: addr=aaaa -> WDATA.
//   10xx_dbbb: disp_on=d, brightness=bbb -> IGNORE.
//   00xx_xxxx: IGNORE; no state change.
//  WDATA byte: RAM[addr] written; ram_wr_stb pulses with addr/data. Then addr+1 (4-bit wrap F->0) if auto, else unchanged.
//  Mode persists across frames until the next data command.
//  READ:
//   - on decode, load shreg = key_scan; sio_data_out_en=1; sio_data_out=shreg[0].
//   - each rising edge sets pend; the next falling edge with pend shifts shreg right and clears pend.
//   - after 8*KEY_BYTES rising edges: sio_data_out_en=0 and out=1 at the next falling edge.
//   - key_scan changes after the load do not affect the frame.
//  STB high: sio_data_out_en=0 within 1 clk of detection. A partial byte (1..7 bits) is discarded, with no write or decode, and frame_err pulses.
//  sio_clk edges while STB high are ignored.
//  A rising and falling sio_clk edge never resolve in the same clk (phase rule). STB rising in the same clk as a byte-completing edge completes the byte first.
//  rst_n low at any time, including mid-read: immediate return to the reset state.
// TESTING
//  1. 0x40 frame; then 0xC0 + bytes 0x00..0x0F in one frame -> RAM[a]=a, 16 ram_wr_stb pulses, addr 0..F.
//  2. 0x44 frame; then 0xC3,0xAA,0x55 -> RAM[3]=0x55, two strobes both addr 3, other bytes unchanged.
//  3. Auto mode, 0xCF,0x11,0x22 -> RAM[15]=0x11, RAM[0]=0x22 (wrap).
//  4. key_scan=0x0403_0201, frame 0x42 + 32 clocks -> master samples 01,02,03,04 LSB first; out_en 0 after STB high.
//  5. 0x8F -> disp_on=1, brightness=7; then 0x80 -> disp_on=0, brightness=0; 0x0F frame -> no change.
//  6. STB high after 5 bits of 0xC0 -> frame_err pulse, no write; rst_n low mid-read -> out_en=0, RAM cleared.

Source files
------------

// File: rtl/tm1638_responder.sv
// TM1638 slave emulation: decodes commands from an asynchronous STB/CLK/DIO master,
// holds the 16-byte display RAM, the display-control state and returns key-scan bytes.
module tm1638_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int KEY_BYTES   = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sio_clk,
    input  logic                     sio_stb,
    input  logic                     sio_data_in,
    output logic                     sio_data_out,
    output logic                     sio_data_out_en,
    input  logic [8*KEY_BYTES-1:0]   key_scan,
    output logic [127:0]             display_ram,
    output logic                     ram_wr_stb,
    output logic [3:0]               ram_wr_addr,
    output logic [7:0]               ram_wr_data,
    output logic                     disp_on,
    output logic [2:0]               brightness,
    output logic                     frame_err
);

    localparam int KEY_BITS = 8 * KEY_BYTES;
    localparam int RD_W     = $clog2(KEY_BITS + 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(KEY_BITS);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_READ,
        ST_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync_r;
    logic [SYNC_STAGES-1:0] stb_sync_r;
    logic [SYNC_STAGES-1:0] dat_sync_r;
    logic                   sclk_d_r;
    logic                   stb_d_r;

    state_t                 state_r;
    logic [2:0]             bit_cnt_r;
    logic [6:0]             bit_shreg_r;
    logic [3:0]             addr_r;
    logic                   fixed_mode_r;
    logic [KEY_BITS-1:0]    key_shreg_r;
    logic [RD_W-1:0]        rd_cnt_r;
    logic                   pend_r;

    logic                   sclk_s;
    logic                   stb_s;
    logic                   din_s;
    logic                   rise_s;
    logic                   fall_s;
    logic                   stb_fall_s;
    logic                   stb_rise_s;
    logic                   bit_take_s;
    logic                   byte_done_s;
    logic [2:0]             bit_cnt_next_s;
    logic [7:0]             byte_full_s;

    assign sclk_s = clk_sync_r[SYNC_STAGES-1];
    assign stb_s  = stb_sync_r[SYNC_STAGES-1];
    assign din_s  = dat_sync_r[SYNC_STAGES-1];

    // Synchronizer chains plus one delayed copy for edge detection; STB idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_r <= '0;
            stb_sync_r <= '1;
            dat_sync_r <= '0;
            sclk_d_r   <= 1'b0;
            stb_d_r    <= 1'b1;
        end else begin
            clk_sync_r <= {clk_sync_r[SYNC_STAGES-2:0], sio_clk};
            stb_sync_r <= {stb_sync_r[SYNC_STAGES-2:0], sio_stb};
            dat_sync_r <= {dat_sync_r[SYNC_STAGES-2:0], sio_data_in};
            sclk_d_r   <= sclk_s;
            stb_d_r    <= stb_s;
        end
    end

    // Edge qualification: clock edges only count while the previous STB sample was low,
    // so a byte completing in the same clk as STB rising is still taken.
    always_comb begin
        rise_s         = sclk_s & ~sclk_d_r & ~stb_d_r;
        fall_s         = ~sclk_s & sclk_d_r & ~stb_d_r;
        stb_fall_s     = ~stb_s & stb_d_r;
        stb_rise_s     = stb_s & ~stb_d_r;
        byte_full_s    = {din_s, bit_shreg_r};
        if (rise_s && ((state_r == ST_CMD) || (state_r == ST_WDATA) || (state_r == ST_IGNORE))) begin
            bit_take_s = 1'b1;
        end else begin
            bit_take_s = 1'b0;
        end
        bit_cnt_next_s = bit_take_s ? (bit_cnt_r + 3'd1) : bit_cnt_r;
        byte_done_s    = bit_take_s && (bit_cnt_r == 3'd7);
    end

    // Protocol FSM: byte assembly, command decode, RAM writes, key readout, frame control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r         <= ST_IDLE;
            bit_cnt_r       <= 3'd0;
            bit_shreg_r     <= 7'd0;
            addr_r          <= 4'd0;
            fixed_mode_r    <= 1'b0;
            key_shreg_r     <= '0;
            rd_cnt_r        <= '0;
            pend_r          <= 1'b0;
            sio_data_out    <= 1'b0;
            sio_data_out_en <= 1'b0;
            display_ram     <= 128'd0;
            ram_wr_stb      <= 1'b0;
            ram_wr_addr     <= 4'd0;
            ram_wr_data     <= 8'd0;
            disp_on         <= 1'b0;
            brightness      <= 3'd0;
            frame_err       <= 1'b0;
        end else begin
            ram_wr_stb <= 1'b0;
            frame_err  <= 1'b0;

            if (bit_take_s) begin
                bit_shreg_r <= byte_full_s[7:1];
                bit_cnt_r   <= bit_cnt_next_s;
            end

            if (byte_done_s) begin
                case (state_r)
                    ST_CMD: begin
                        case (byte_full_s[7:6])
                            2'b01: begin
                                if (byte_full_s[1]) begin
                                    state_r         <= ST_READ;
                                    key_shreg_r     <= key_scan;
                                    sio_data_out    <= key_scan[0];
                                    sio_data_out_en <= 1'b1;
                                    rd_cnt_r        <= '0;
                                    pend_r          <= 1'b0;
                                end else begin
                                    fixed_mode_r    <= byte_full_s[2];
                                    state_r         <= ST_IGNORE;
                                end
                            end
                            2'b11: begin
                                addr_r  <= byte_full_s[3:0];
                                state_r <= ST_WDATA;
                            end
                            2'b10: begin
                                disp_on    <= byte_full_s[3];
                                brightness <= byte_full_s[2:0];
                                state_r    <= ST_IGNORE;
                            end
                            default: begin
                                state_r <= ST_IGNORE;
                            end
                        endcase
                    end
                    ST_WDATA: begin
                        display_ram[{addr_r, 3'b000} +: 8] <= byte_full_s;
                        ram_wr_stb  <= 1'b1;
                        ram_wr_addr <= addr_r;
                        ram_wr_data <= byte_full_s;
                        if (!fixed_mode_r) begin
                            addr_r <= addr_r + 4'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end

            // Read phase: rising edge arms a shift, the following falling edge performs it.
            if (state_r == ST_READ) begin
                if (rise_s && (rd_cnt_r != RD_LAST)) begin
                    rd_cnt_r <= rd_cnt_r + RD_W'(1);
                    pend_r   <= 1'b1;
                end
                if (fall_s && pend_r) begin
                    pend_r <= 1'b0;
                    if (rd_cnt_r == RD_LAST) begin
                        sio_data_out_en <= 1'b0;
                        sio_data_out    <= 1'b1;
                    end else begin
                        key_shreg_r  <= {1'b0, key_shreg_r[KEY_BITS-1:1]};
                        sio_data_out <= key_shreg_r[1];
                    end
                end
            end

            if (stb_fall_s) begin
                state_r   <= ST_CMD;
                bit_cnt_r <= 3'd0;
            end else if (stb_rise_s) begin
                state_r         <= ST_IDLE;
                bit_cnt_r       <= 3'd0;
                pend_r          <= 1'b0;
                sio_data_out_en <= 1'b0;
                frame_err       <= (bit_cnt_next_s != 3'd0);
            end
        end
    end

endmodule

// File: tb/tb_tm1638_responder.sv
// Randomized bench for tm1638_responder: a bit-banging master, a frame-level
// reference model of the chip, and a scoreboard fed by the RAM write strobe.
module tb_tm1638_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         sio_clk = 1'b1;
    logic         sio_stb = 1'b1;
    logic         sio_data_in = 1'b0;
    logic         sio_data_out;
    logic         sio_data_out_en;
    logic [31:0]  key_scan = 32'd0;
    logic [127:0] display_ram;
    logic         ram_wr_stb;
    logic [3:0]   ram_wr_addr;
    logic [7:0]   ram_wr_data;
    logic         disp_on;
    logic [2:0]   brightness;
    logic         frame_err;

    tm1638_responder #(.SYNC_STAGES(2), .KEY_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .sio_clk(sio_clk), .sio_stb(sio_stb),
        .sio_data_in(sio_data_in), .sio_data_out(sio_data_out),
        .sio_data_out_en(sio_data_out_en), .key_scan(key_scan),
        .display_ram(display_ram), .ram_wr_stb(ram_wr_stb),
        .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .disp_on(disp_on), .brightness(brightness), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int exp_ferr = 0;
    int got_ferr = 0;

    logic [11:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  fq[$];

    logic [7:0]  m_ram[16];
    bit          m_fixed = 1'b0;
    logic        m_on = 1'b0;
    logic [2:0]  m_bri = 3'd0;

    task automatic check(input string name, input logic [159:0] got, input logic [159:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every write strobe must match the oldest predicted write.
    always @(negedge clk) begin
        if (rst_n && ram_wr_stb) begin
            tests++;
            if (wr_q.size() == 0) begin
                fails++;
                $display("FAIL wr_unexpected: got addr %0h data %0h expected none", ram_wr_addr, ram_wr_data);
            end else begin
                logic [11:0] e;
                e = wr_q.pop_front();
                if ({ram_wr_addr, ram_wr_data} !== e) begin
                    fails++;
                    $display("FAIL wr_stb: got %0h expected %0h", {ram_wr_addr, ram_wr_data}, e);
                end
            end
        end
        if (rst_n && frame_err) got_ferr++;
    end

    function automatic logic [127:0] ram_flat();
        logic [127:0] r;
        for (int a = 0; a < 16; a++) r[8*a +: 8] = m_ram[a];
        return r;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 16; a++) m_ram[a] = 8'd0;
        m_fixed = 1'b0;
        m_on    = 1'b0;
        m_bri   = 3'd0;
    endtask

    // Frame-level chip behaviour: the first byte is the command, the rest is data.
    task automatic model_frame();
        logic [7:0] c;
        logic [3:0] a;
        c = fq[0];
        case (c[7:6])
            2'b01: if (!c[1]) m_fixed = c[2];
            2'b11: begin
                a = c[3:0];
                for (int i = 1; i < fq.size(); i++) begin
                    wr_q.push_back({a, fq[i]});
                    m_ram[a] = fq[i];
                    if (!m_fixed) a = a + 4'd1;
                end
            end
            2'b10: begin
                m_on  = c[3];
                m_bri = c[2:0];
            end
            default: ;
        endcase
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sio_clk = 1'b0;
            sio_data_in = b[i];
            wait_clk(8);
            sio_clk = 1'b1;
            wait_clk(8);
        end
    endtask

    task automatic start_frame();
        sio_stb = 1'b0;
        wait_clk(8);
    endtask

    task automatic end_frame();
        wait_clk(4);
        sio_stb = 1'b1;
        wait_clk(8);
    endtask

    task automatic check_state(input string name);
        check({name, "_ram"}, display_ram, ram_flat());
        check({name, "_disp"}, {disp_on, brightness}, {m_on, m_bri});
        check({name, "_ferr"}, got_ferr, exp_ferr);
        check({name, "_wrq"}, wr_q.size(), 0);
    endtask

    task automatic do_frame(input string name);
        model_frame();
        start_frame();
        foreach (fq[i]) send_bits(fq[i], 8);
        end_frame();
        check_state(name);
    endtask

    task automatic do_read(input logic [31:0] keys, input string name);
        logic [31:0] got;
        key_scan = keys;
        for (int k = 0; k < 4; k++) rd_q.push_back(keys[8*k +: 8]);
        start_frame();
        send_bits(8'h42, 8);
        key_scan = $urandom();
        check({name, "_oe_on"}, sio_data_out_en, 1'b1);
        for (int i = 0; i < 32; i++) begin
            sio_clk = 1'b0;
            wait_clk(8);
            got[i] = sio_data_out;
            sio_clk = 1'b1;
            wait_clk(8);
        end
        sio_clk = 1'b0;
        wait_clk(8);
        check({name, "_release"}, {sio_data_out_en, sio_data_out}, 2'b01);
        for (int k = 0; k < 4; k++) check({name, "_byte"}, got[8*k +: 8], rd_q.pop_front());
        end_frame();
        sio_clk = 1'b1;
        wait_clk(8);
        check({name, "_oe_off"}, sio_data_out_en, 1'b0);
    endtask

    initial begin
        model_reset();
        wait_clk(3);
        check("reset_outputs",
              {sio_data_out, sio_data_out_en, display_ram, ram_wr_stb, ram_wr_addr,
               ram_wr_data, disp_on, brightness, frame_err}, 160'd0);
        rst_n = 1'b1;
        wait_clk(4);

        // Auto-increment fill of the whole RAM.
        fq.delete(); fq.push_back(8'h40); do_frame("t1_mode");
        fq.delete(); fq.push_back(8'hC0);
        for (int i = 0; i < 16; i++) fq.push_back(8'(i));
        do_frame("t1_fill");

        // Fixed address: both writes land on address 3.
        fq.delete(); fq.push_back(8'h44); do_frame("t2_mode");
        fq.delete(); fq.push_back(8'hC3); fq.push_back(8'hAA); fq.push_back(8'h55);
        do_frame("t2_fixed");

        // Address wrap F -> 0.
        fq.delete(); fq.push_back(8'h40); do_frame("t3_mode");
        fq.delete(); fq.push_back(8'hCF); fq.push_back(8'h11); fq.push_back(8'h22);
        do_frame("t3_wrap");

        do_read(32'h0403_0201, "t4_read");

        fq.delete(); fq.push_back(8'h8F); do_frame("t5_on");
        fq.delete(); fq.push_back(8'h80); do_frame("t5_off");
        fq.delete(); fq.push_back(8'h8D); do_frame("t5_mid");
        fq.delete(); fq.push_back(8'h0F); do_frame("t5_ignore");

        for (int n = 0; n < 24; n++) begin
            int kind;
            kind = $urandom_range(0, 4);
            fq.delete();
            case (kind)
                0: fq.push_back(8'h40 | (8'($urandom()) & 8'h3D));
                1: begin
                    fq.push_back(8'hC0 | (8'($urandom()) & 8'h3F));
                    for (int j = 0; j < $urandom_range(1, 6); j++) fq.push_back(8'($urandom()));
                end
                2: fq.push_back(8'h80 | (8'($urandom()) & 8'h3F));
                3: begin
                    fq.push_back(8'($urandom()) & 8'h3F);
                    fq.push_back(8'($urandom()));
                end
                default: ;
            endcase
            if (kind == 4) do_read($urandom(), "rnd_read");
            else do_frame("rnd_frame");
        end

        // Partial byte: discarded with an error pulse.
        exp_ferr++;
        start_frame();
        send_bits(8'hC0, 5);
        end_frame();
        check_state("t6_partial");

        // Reset in the middle of a read.
        fq.delete(); fq.push_back(8'h8B); do_frame("t6_pre");
        key_scan = 32'hDEAD_BEEF;
        start_frame();
        send_bits(8'h42, 8);
        for (int i = 0; i < 5; i++) begin
            sio_clk = 1'b0; wait_clk(8);
            sio_clk = 1'b1; wait_clk(8);
        end
        check("t6_oe_before_rst", sio_data_out_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_outputs", {sio_data_out_en, display_ram, disp_on, brightness}, 160'd0);
        model_reset();
        sio_stb = 1'b1;
        sio_clk = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        fq.delete(); fq.push_back(8'hC0); fq.push_back(8'h12); fq.push_back(8'h34);
        do_frame("t6_post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
